// File: rtl/sales_ledger_arbiter.sv
// Round-robin sales arbiter feeding a saturating total with a req/ack clear.
// Optional SALES_TXN_COUNT_EN adds granted-transaction counters.
module sales_ledger_arbiter #(
  parameter int NUM_CH = 4,
  parameter int AMT_W  = 8,
  parameter int TOT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       sale_req,
  input  logic [NUM_CH*AMT_W-1:0] sale_amt,
  output logic [NUM_CH-1:0]       sale_ack,
  input  logic                    clear_req,
  output logic                    clear_ack,
  output logic [TOT_W-1:0]        sales_total,
  output logic [TOT_W-1:0]        cleared_total,
  output logic                    total_sat,
`ifdef SALES_TXN_COUNT_EN
  output logic [15:0]             txn_count,
  output logic [15:0]             cleared_txn_count,
`endif
  output logic                    busy
);

  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    RUN,
    CLEAR,
    WAIT_LOW
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_CH-1:0] sale_ack_q, sale_ack_d;
  logic              clear_ack_q, clear_ack_d;
  logic [TOT_W-1:0]  sales_total_q, sales_total_d;
  logic [TOT_W-1:0]  cleared_total_q, cleared_total_d;
  logic              total_sat_q, total_sat_d;
`ifdef SALES_TXN_COUNT_EN
  logic [15:0]       txn_count_q, txn_count_d;
  logic [15:0]       cleared_txn_q, cleared_txn_d;
`endif

  logic [AMT_W-1:0]  amt_a [NUM_CH];
  logic [NUM_CH-1:0] elig;
  logic              gnt_vld;
  logic [PW-1:0]     gnt_idx;
  logic [AMT_W-1:0]  gnt_amt;
  logic [TOT_W:0]    sum;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_amt
    assign amt_a[i] = sale_amt[i*AMT_W +: AMT_W];
  end

  // Masking the current ack stops a held req being granted twice in a row.
  assign elig = sale_req & ~sale_ack_q;

  always_comb begin : arb
    int idx;
    logic [PW-1:0] sel;
    idx     = 0;
    sel     = '0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    gnt_amt = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      sel = PW'(idx);
      if (!gnt_vld && elig[sel]) begin
        gnt_vld = 1'b1;
        gnt_idx = sel;
        gnt_amt = amt_a[sel];
      end
    end
  end

  assign sum = {1'b0, sales_total_q}
             + {{(TOT_W+1-AMT_W){1'b0}}, gnt_amt};

  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    sale_ack_d      = '0;
    clear_ack_d     = 1'b0;
    sales_total_d   = sales_total_q;
    cleared_total_d = cleared_total_q;
    total_sat_d     = total_sat_q;
`ifdef SALES_TXN_COUNT_EN
    txn_count_d     = txn_count_q;
    cleared_txn_d   = cleared_txn_q;
`endif
    unique case (state_q)
      RUN: begin
        if (clear_req) begin
          state_d = CLEAR;
        end else if (gnt_vld) begin
          sale_ack_d = NUM_CH'(1) << gnt_idx;
          rr_ptr_d   = (gnt_idx == PW'(NUM_CH-1))
                     ? '0 : gnt_idx + 1'b1;
          if (sum[TOT_W]) begin
            sales_total_d = '1;
            total_sat_d   = 1'b1;
          end else begin
            sales_total_d = sum[TOT_W-1:0];
          end
`ifdef SALES_TXN_COUNT_EN
          txn_count_d = txn_count_q + 16'd1;
`endif
        end
      end
      CLEAR: begin
        cleared_total_d = sales_total_q;
        sales_total_d   = '0;
        total_sat_d     = 1'b0;
        clear_ack_d     = 1'b1;
        state_d         = WAIT_LOW;
`ifdef SALES_TXN_COUNT_EN
        cleared_txn_d   = txn_count_q;
        txn_count_d     = '0;
`endif
      end
      WAIT_LOW: begin
        if (!clear_req) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= RUN;
      rr_ptr_q        <= '0;
      sale_ack_q      <= '0;
      clear_ack_q     <= 1'b0;
      sales_total_q   <= '0;
      cleared_total_q <= '0;
      total_sat_q     <= 1'b0;
`ifdef SALES_TXN_COUNT_EN
      txn_count_q     <= '0;
      cleared_txn_q   <= '0;
`endif
    end else begin
      state_q         <= state_d;
      rr_ptr_q        <= rr_ptr_d;
      sale_ack_q      <= sale_ack_d;
      clear_ack_q     <= clear_ack_d;
      sales_total_q   <= sales_total_d;
      cleared_total_q <= cleared_total_d;
      total_sat_q     <= total_sat_d;
`ifdef SALES_TXN_COUNT_EN
      txn_count_q     <= txn_count_d;
      cleared_txn_q   <= cleared_txn_d;
`endif
    end
  end

  assign sale_ack      = sale_ack_q;
  assign clear_ack     = clear_ack_q;
  assign sales_total   = sales_total_q;
  assign cleared_total = cleared_total_q;
  assign total_sat     = total_sat_q;
  assign busy          = (state_q != RUN);
`ifdef SALES_TXN_COUNT_EN
  assign txn_count         = txn_count_q;
  assign cleared_txn_count = cleared_txn_q;
`endif

endmodule
